// File: rtl/mmio_status_responder.sv
// mmio_status_responder
//
// Memory-mapped responder for simulation and test environments. It provides:
//   - console register: a write pushes one byte into a FIFO that drains over
//     the char_* stream; a read returns the current FIFO occupancy
//   - status register: magic values pulse tests_passed_o / tests_failed_o
//   - exit register (STATUS_ADDR+4): latches an exit code and pulses exit_valid_o
//   - optional free-running cycle counter at TIMER_ADDR, enabled by defining
//     the macro MMIO_RESP_CYCLE_CNT_EN (otherwise TIMER_ADDR is unmapped)
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   data_req_i / data_gnt_o    request / combinational grant
//   data_addr_i                byte address (bits [1:0] ignored)
//   data_we_i, data_be_i       write enable, byte enables
//   data_wdata_i               write data
//   data_rvalid_o              response valid, one cycle after each grant
//   data_rdata_o               read data (zero when data_rvalid_o is low)
//   char_valid_o/char_data_o/char_ready_i   console byte stream
//   tests_passed_o, tests_failed_o, exit_valid_o   one-cycle pulses
//   exit_value_o               last exit code written

module mmio_status_responder #(
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
    parameter logic [31:0] STATUS_ADDR  = 32'h2000_0000,
    parameter logic [31:0] TIMER_ADDR   = 32'h1500_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        char_valid_o,
    output logic [7:0]  char_data_o,
    input  logic        char_ready_i,
    output logic        tests_passed_o,
    output logic        tests_failed_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o
);

    localparam int unsigned PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW        = PW + 1;
    localparam logic [31:0] EXIT_ADDR = STATUS_ADDR + 32'd4;
    localparam logic [31:0] PASS_CODE = 32'd123456789;
    localparam logic [31:0] FAIL_CODE = 32'd1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]    fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          rvalid_q, rvalid_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          passed_q, passed_d;
    logic          failed_q, failed_d;
    logic          exit_valid_q, exit_valid_d;
    logic [31:0]   exit_value_q, exit_value_d;

    // ------------------------------------------------------------------
    // Address decode (word granularity)
    // ------------------------------------------------------------------
    logic hit_console, hit_status, hit_exit, hit_timer;
    logic fifo_full, push, pop;
    logic [31:0] rdata_sel;

    assign hit_console = (data_addr_i[31:2] == CONSOLE_ADDR[31:2]);
    assign hit_status  = (data_addr_i[31:2] == STATUS_ADDR[31:2]);
    assign hit_exit    = (data_addr_i[31:2] == EXIT_ADDR[31:2]);
    assign hit_timer   = (data_addr_i[31:2] == TIMER_ADDR[31:2]);

    // Full is judged on the registered count only: a pop in this cycle does
    // not make room for a push in the same cycle.
    assign fifo_full  = (count_q == FULL_CNT);
    assign data_gnt_o = rst_n && data_req_i && !(hit_console && data_we_i && fifo_full);

    assign push = data_gnt_o && hit_console && data_we_i && data_be_i[0];
    assign pop  = char_valid_o && char_ready_i;

    assign char_valid_o = (count_q != '0);
    assign char_data_o  = fifo_mem_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Optional cycle counter
    // ------------------------------------------------------------------
`ifdef MMIO_RESP_CYCLE_CNT_EN
    logic [31:0] cycle_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
        end
    end

    logic unused_sink;
    assign unused_sink = ^{data_be_i[3:1], data_addr_i[1:0]};
`else
    logic unused_sink;
    assign unused_sink = ^{data_be_i[3:1], data_addr_i[1:0], hit_timer};
`endif

    // ------------------------------------------------------------------
    // Read mux (evaluated in the grant cycle)
    // ------------------------------------------------------------------
    always_comb begin
        rdata_sel = '0;
        if (hit_console) begin
            rdata_sel = 32'(count_q);
        end else if (hit_status) begin
            rdata_sel = '0;
        end else if (hit_exit) begin
            rdata_sel = exit_value_q;
`ifdef MMIO_RESP_CYCLE_CNT_EN
        end else if (hit_timer) begin
            rdata_sel = cycle_cnt_q;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        rvalid_d     = data_gnt_o;
        rdata_d      = (data_gnt_o && !data_we_i) ? rdata_sel : '0;
        passed_d     = data_gnt_o && data_we_i && hit_status && (data_wdata_i == PASS_CODE);
        failed_d     = data_gnt_o && data_we_i && hit_status && (data_wdata_i == FAIL_CODE);
        exit_valid_d = data_gnt_o && data_we_i && hit_exit;
        exit_value_d = exit_valid_d ? data_wdata_i : exit_value_q;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            passed_q     <= 1'b0;
            failed_q     <= 1'b0;
            exit_valid_q <= 1'b0;
            exit_value_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            passed_q     <= passed_d;
            failed_q     <= failed_d;
            exit_valid_q <= exit_valid_d;
            exit_value_q <= exit_value_d;
        end
    end

    // FIFO storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= data_wdata_i[7:0];
        end
    end

    assign data_rvalid_o  = rvalid_q;
    assign data_rdata_o   = rdata_q;
    assign tests_passed_o = passed_q;
    assign tests_failed_o = failed_q;
    assign exit_valid_o   = exit_valid_q;
    assign exit_value_o   = exit_value_q;

endmodule

// File: tb/tb_mmio_status_responder.sv
module tb_mmio_status_responder;

    localparam int unsigned DEPTH  = 16;
    localparam logic [31:0] A_CON  = 32'h1000_0000;
    localparam logic [31:0] A_STAT = 32'h2000_0000;
    localparam logic [31:0] A_EXIT = 32'h2000_0004;
    localparam logic [31:0] A_TIM  = 32'h1500_0000;
    localparam logic [31:0] A_NONE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        data_req_i = 1'b0;
    logic        data_gnt_o;
    logic [31:0] data_addr_i = '0;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = '0;
    logic [31:0] data_wdata_i = '0;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        char_valid_o;
    logic [7:0]  char_data_o;
    logic        char_ready_i = 1'b0;
    logic        tests_passed_o, tests_failed_o, exit_valid_o;
    logic [31:0] exit_value_o;

    int checks = 0;
    int failures = 0;

    mmio_status_responder #(
        .FIFO_DEPTH  (DEPTH),
        .CONSOLE_ADDR(A_CON),
        .STATUS_ADDR (A_STAT),
        .TIMER_ADDR  (A_TIM)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_req_i    (data_req_i),
        .data_gnt_o    (data_gnt_o),
        .data_addr_i   (data_addr_i),
        .data_we_i     (data_we_i),
        .data_be_i     (data_be_i),
        .data_wdata_i  (data_wdata_i),
        .data_rvalid_o (data_rvalid_o),
        .data_rdata_o  (data_rdata_o),
        .char_valid_o  (char_valid_o),
        .char_data_o   (char_data_o),
        .char_ready_i  (char_ready_i),
        .tests_passed_o(tests_passed_o),
        .tests_failed_o(tests_failed_o),
        .exit_valid_o  (exit_valid_o),
        .exit_value_o  (exit_value_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {31'b0, act}, {31'b0, exp});
    endtask

    // ------------------------------------------------------------------
    // Reference model: register map behaviour on a byte queue
    // ------------------------------------------------------------------
    logic [7:0]  m_fifo [$];
    logic        m_rvalid = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        m_pass = 1'b0, m_fail = 1'b0, m_exitv = 1'b0;
    logic [31:0] m_exit_val = '0;
    logic [31:0] m_cnt = '0;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

    always @(negedge clk) begin
        logic        exp_gnt;
        logic        wr;
        logic [31:0] wa;
        logic [31:0] rd;
        if (!rst_n) begin
            m_fifo.delete();
            m_rvalid = 1'b0;
            m_rdata = '0;
            m_pass = 1'b0;
            m_fail = 1'b0;
            m_exitv = 1'b0;
            m_exit_val = '0;
            m_cnt = '0;
        end
        wa = word(data_addr_i);
        wr = data_we_i;
        exp_gnt = rst_n && data_req_i && !(wa == A_CON && wr && m_fifo.size() == DEPTH);

        check1("gnt", data_gnt_o, exp_gnt);
        check1("rvalid", data_rvalid_o, m_rvalid);
        check("rdata", data_rdata_o, m_rdata);
        check1("passed", tests_passed_o, m_pass);
        check1("failed", tests_failed_o, m_fail);
        check1("exit_valid", exit_valid_o, m_exitv);
        check("exit_value", exit_value_o, m_exit_val);
        check1("char_valid", char_valid_o, m_fifo.size() > 0);
        if (m_fifo.size() > 0) check("char_data", {24'b0, char_data_o}, {24'b0, m_fifo[0]});

        if (rst_n) begin
            rd = '0;
            if (exp_gnt && !wr) begin
                if (wa == A_CON) rd = m_fifo.size();
                else if (wa == A_EXIT) rd = m_exit_val;
`ifdef MMIO_RESP_CYCLE_CNT_EN
                else if (wa == A_TIM) rd = m_cnt;
`endif
            end
            m_rvalid = exp_gnt;
            m_rdata = rd;
            m_pass = exp_gnt && wr && wa == A_STAT && data_wdata_i == 32'd123456789;
            m_fail = exp_gnt && wr && wa == A_STAT && data_wdata_i == 32'd1;
            m_exitv = exp_gnt && wr && wa == A_EXIT;
            if (m_exitv) m_exit_val = data_wdata_i;
            if (m_fifo.size() > 0 && char_ready_i) void'(m_fifo.pop_front());
            if (exp_gnt && wr && wa == A_CON && data_be_i[0]) m_fifo.push_back(data_wdata_i[7:0]);
            m_cnt = m_cnt + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus with hand-computed expectations
    // ------------------------------------------------------------------
    task automatic bus(input logic [31:0] a, input logic we, input logic [3:0] be,
                       input logic [31:0] wd, output logic [31:0] rd);
        int unsigned n;
        @(posedge clk); #1;
        data_req_i = 1'b1;
        data_addr_i = a;
        data_we_i = we;
        data_be_i = be;
        data_wdata_i = wd;
        n = 0;
        @(negedge clk);
        while (!data_gnt_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!data_gnt_o) begin
            checks++;
            failures++;
            $display("FAIL gnt_timeout actual=0 required=1 addr=0x%08h", a);
        end
        @(posedge clk); #1;
        data_req_i = 1'b0;
        data_we_i = 1'b0;
        @(negedge clk);
        rd = data_rdata_o;
    endtask

    initial begin
        logic [31:0] rd, t1, t2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("reset_rvalid", data_rvalid_o, 1'b0);
        check1("reset_char_valid", char_valid_o, 1'b0);
        check("reset_exit_value", exit_value_o, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        char_ready_i = 1'b1;

        // Console bytes drain in order
        bus(A_CON, 1'b1, 4'hF, 32'h0000_0048, rd);
        check1("con_valid_48", char_valid_o, 1'b1);
        check("con_data_48", {24'b0, char_data_o}, 32'h48);
        bus(A_CON, 1'b1, 4'h1, 32'h0000_0169, rd);
        check1("con_valid_69", char_valid_o, 1'b1);
        check("con_data_69", {24'b0, char_data_o}, 32'h69);
        bus(A_CON, 1'b0, 4'hF, 32'h0, rd);
        check("con_occ_empty", rd, 32'd0);
        bus(A_CON, 1'b1, 4'hE, 32'h0000_0055, rd);
        check1("con_be0_nopush", char_valid_o, 1'b0);

        // Status and exit registers
        bus(A_STAT, 1'b1, 4'h0, 32'd123456789, rd);
        check1("pass_pulse", tests_passed_o, 1'b1);
        check1("pass_nofail", tests_failed_o, 1'b0);
        @(negedge clk);
        check1("pass_one_cycle", tests_passed_o, 1'b0);
        bus(A_STAT, 1'b1, 4'hF, 32'd1, rd);
        check1("fail_pulse", tests_failed_o, 1'b1);
        bus(A_STAT, 1'b1, 4'hF, 32'd5, rd);
        check1("five_nopass", tests_passed_o, 1'b0);
        check1("five_nofail", tests_failed_o, 1'b0);
        bus(A_STAT, 1'b0, 4'hF, 32'h0, rd);
        check("status_read", rd, 32'h0);
        bus(A_EXIT, 1'b1, 4'h0, 32'h0000_002A, rd);
        check1("exit_pulse", exit_valid_o, 1'b1);
        check("exit_value", exit_value_o, 32'h2A);
        @(negedge clk);
        check1("exit_one_cycle", exit_valid_o, 1'b0);
        check("exit_hold", exit_value_o, 32'h2A);
        bus(A_EXIT | 32'h2, 1'b0, 4'hF, 32'h0, rd);
        check("exit_readback", rd, 32'h2A);

        // Unmapped
        bus(A_NONE, 1'b1, 4'hF, 32'hDEAD_BEEF, rd);
        bus(A_NONE, 1'b0, 4'hF, 32'h0, rd);
        check("unmapped_read", rd, 32'h0);

        // Timer: grants 10 cycles apart
        bus(A_TIM, 1'b0, 4'hF, 32'h0, t1);
        repeat (8) @(posedge clk);
        bus(A_TIM, 1'b0, 4'hF, 32'h0, t2);
`ifdef MMIO_RESP_CYCLE_CNT_EN
        check("timer_delta", t2 - t1, 32'd10);
`else
        check("timer_t1_zero", t1, 32'h0);
        check("timer_t2_zero", t2, 32'h0);
`endif

        // Fill FIFO back-to-back, then overflow attempt
        @(posedge clk); #1;
        char_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            data_req_i = 1'b1;
            data_we_i = 1'b1;
            data_addr_i = A_CON;
            data_be_i = 4'hF;
            data_wdata_i = 32'hA0 + 32'(i);
            @(negedge clk);
            check1("fill_gnt", data_gnt_o, 1'b1);
            @(posedge clk); #1;
        end
        data_req_i = 1'b0;
        data_we_i = 1'b0;
        bus(A_CON, 1'b0, 4'hF, 32'h0, rd);
        check("con_occ_full", rd, 32'd16);
        @(posedge clk); #1;
        data_req_i = 1'b1;
        data_we_i = 1'b1;
        data_addr_i = A_CON;
        data_be_i = 4'hF;
        data_wdata_i = 32'hB0;
        repeat (3) begin
            @(negedge clk);
            check1("full_gnt_low", data_gnt_o, 1'b0);
            @(posedge clk); #1;
        end
        char_ready_i = 1'b1;
        @(negedge clk);
        check1("pop_cycle_gnt_low", data_gnt_o, 1'b0);
        check("head_a0", {24'b0, char_data_o}, 32'hA0);
        @(posedge clk); #1;
        char_ready_i = 1'b0;
        @(negedge clk);
        check1("after_pop_gnt", data_gnt_o, 1'b1);
        @(posedge clk); #1;
        data_req_i = 1'b0;
        data_we_i = 1'b0;
        char_ready_i = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        char_ready_i = 1'b0;
        @(negedge clk);
        check1("drained", char_valid_o, 1'b0);

        // Reset with bytes queued and a read in flight
        bus(A_CON, 1'b1, 4'hF, 32'h31, rd);
        bus(A_CON, 1'b1, 4'hF, 32'h32, rd);
        bus(A_CON, 1'b1, 4'hF, 32'h33, rd);
        @(posedge clk); #1;
        data_req_i = 1'b1;
        data_we_i = 1'b0;
        data_addr_i = A_CON;
        @(negedge clk);
        check1("inflight_gnt", data_gnt_o, 1'b1);
        #1;
        rst_n = 1'b0;
        data_addr_i = A_NONE;
        @(negedge clk);
        check1("rst_no_rvalid", data_rvalid_o, 1'b0);
        check1("rst_char_valid", char_valid_o, 1'b0);
        check1("rst_gnt_low", data_gnt_o, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        data_req_i = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check1("post_rst_no_rvalid", data_rvalid_o, 1'b0);
        bus(A_CON, 1'b0, 4'hF, 32'h0, rd);
        check("post_rst_occ", rd, 32'd0);
        check1("post_rst_char_valid", char_valid_o, 1'b0);
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
